// File: rtl/adc_xmit_pkg.sv
// Shared types and constants for the ADC line transmitter and its receive-side checker.
package adc_xmit_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_TRAIN = 1'b1
  } xmit_state_e;

  localparam logic [7:0] ADCTX_TRAIN_PAT = 8'h38;
  localparam logic [7:0] ADCTX_IDLE_PAT  = 8'h00;

  // PRBS-7, x^7 + x^6 + 1
  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/xmit_fifo2.sv
// Two-entry valid/ready buffer with occupancy count; no bypass from push to head.
module xmit_fifo2 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  assign ready = (count < 2'd2);
  assign empty = (count == 2'd0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_line_xmit.sv
// Single-line ADC serial-stream emulator: MSB-first words with frame marker, training and idle fill.
// Optional ADCTX_PRBS_EN adds a PRBS input selecting PRBS-7 words over buffered data.
module adc_line_xmit
  import adc_xmit_pkg::*;
#(
  parameter int unsigned WIDTH     = 6,
  parameter logic [7:0]  TRAIN_PAT = ADCTX_TRAIN_PAT,
  parameter logic [7:0]  IDLE_PAT  = ADCTX_IDLE_PAT,
  parameter int unsigned UCNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  DIN,
  input  logic              DVALID,
  output logic              DREADY,
  input  logic              TRAIN,
`ifdef ADCTX_PRBS_EN
  input  logic              PRBS,
`endif
  output logic              SOUT,
  output logic              FRAME,
  output logic              TRAINING,
  output logic              UNDERRUN,
  output logic [UCNT_W-1:0] UCNT
);

  localparam int unsigned      CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TRAIN_W = WIDTH'(TRAIN_PAT);
  localparam logic [WIDTH-1:0] IDLE_W  = WIDTH'(IDLE_PAT);

  xmit_state_e      state;
  xmit_state_e      next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] load_word;
  logic             boundary;
  logic             load_idle;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_ready;

  assign push   = DVALID && fifo_ready;
  assign DREADY = fifo_ready;

  xmit_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .din   (DIN),
    .push  (push),
    .ready (fifo_ready),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

`ifdef ADCTX_PRBS_EN
  logic [6:0] lfsr;
  logic       lfsr_step;

  always_ff @(posedge CLK) begin
    if (RST)            lfsr <= PRBS7_SEED;
    else if (lfsr_step) lfsr <= prbs7_next(lfsr);
  end
`endif

  // Load selection only happens on the boundary; priority TRAIN > PRBS > buffer > idle.
  always_comb begin
    boundary   = (cnt == LAST);
    next_state = state;
    load_word  = IDLE_W;
    load_idle  = 1'b0;
    pop        = 1'b0;
`ifdef ADCTX_PRBS_EN
    lfsr_step  = 1'b0;
`endif
    if (boundary) begin
      if (TRAIN) begin
        next_state = ST_TRAIN;
        load_word  = TRAIN_W;
      end
`ifdef ADCTX_PRBS_EN
      else if (PRBS) begin
        next_state = ST_RUN;
        load_word  = WIDTH'(lfsr);
        lfsr_step  = 1'b1;
      end
`endif
      else if (!fifo_empty) begin
        next_state = ST_RUN;
        load_word  = fifo_dout;
        pop        = 1'b1;
      end else begin
        next_state = ST_RUN;
        load_idle  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_RUN;
    else     state <= next_state;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= LAST;
      sr       <= '0;
      UNDERRUN <= 1'b0;
      UCNT     <= '0;
    end else begin
      if (boundary) begin
        cnt <= '0;
        sr  <= load_word;
      end else begin
        cnt <= cnt + 1'b1;
        sr  <= {sr[WIDTH-2:0], 1'b0};
      end
      UNDERRUN <= load_idle;
      if (load_idle && (UCNT != '1)) UCNT <= UCNT + 1'b1;
    end
  end

  assign SOUT     = sr[WIDTH-1];
  assign FRAME    = (cnt == '0);
  assign TRAINING = (state == ST_TRAIN);

endmodule

// File: doc/adc_line_xmit.md
Name: adc_line_xmit

Overview:
- Single-line ADC serial-stream emulator: the transmit counterpart of the per-line ADC deserializer.
- Serializes WIDTH-bit words MSB-first onto one fabric-rate line, one bit per CLK, with a frame marker on each word's first bit.
- Used for loopback and bench stimulus of the receive chain, including bitslip/delay alignment via a training pattern.
- Fed through a 2-entry buffer with valid/ready handshake; keeps the stream continuous by inserting an idle word on underrun.

Parameters:
- WIDTH, 6: bits per word (2..8).
- TRAIN_PAT, 6'b111000: word sent continuously while training.
- IDLE_PAT, 6'b000000: word sent on underrun.
- UCNT_W, 16: width of the underrun counter.

Ports:
- CLK  in  1  fabric clock; all logic on rising edge.
- RST  in  1  synchronous reset, active high.
- DIN  in  WIDTH  data word to transmit.
- DVALID  in  1  DIN valid.
- DREADY  out  1  buffer can accept; a word transfers on a CLK edge with DVALID&&DREADY.
- TRAIN  in  1  training request, level.
- SOUT  out  1  serial data.
- FRAME  out  1  high while SOUT carries a word's MSB.
- TRAINING  out  1  state == TRAIN.
- UNDERRUN  out  1  one-cycle pulse when IDLE_PAT is loaded.
- UCNT  out  UCNT_W  saturating underrun count.

Behaviour:
- Reset values:
  - Outputs: SOUT=0, FRAME=0, TRAINING=0, UNDERRUN=0, UCNT=0, DREADY=1 (buffer empty).
  - Internals: bit counter cnt=WIDTH-1, shift register=0, state=RUN, buffer count=0.
  - RST mid-word truncates the word immediately; no partial word survives; buffered words are discarded.
- Bit counter:
  - cnt runs 0..WIDTH-1 continuously and wraps.
  - Boundary cycle = cnt==WIDTH-1; the first cycle after reset is therefore a boundary.
- Load selection at each boundary, first match wins:
  - TRAIN=1: TRAIN_PAT; state becomes TRAIN.
  - Buffer non-empty: pop head; state becomes RUN.
  - Otherwise: IDLE_PAT; UNDERRUN=1 next cycle; UCNT+1, saturating at all-ones.
- State machine:
  - RUN -> TRAIN and TRAIN -> RUN change only at boundaries, from TRAIN sampled there.
  - TRAIN pops nothing; buffered data is held until training ends.
- Output timing:
  - SOUT = shift-register MSB; the register shifts left each non-boundary cycle.
  - The loaded word's MSB appears on SOUT the cycle after the boundary, with FRAME=1.
  - FRAME is high exactly 1 of every WIDTH cycles.
- Buffer:
  - 2-entry FIFO; DREADY = count<2, combinational from registered count.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - No bypass: a word pushed on a boundary cycle with an empty buffer is not sent that boundary; IDLE_PAT is sent and an underrun is counted.
- Latency: a word accepted into an empty buffer in RUN appears at the next boundary+1; minimum 2 cycles, maximum WIDTH+1 cycles.
- Throughput: one word per WIDTH cycles, gapless when fed.
- DIN bits above WIDTH are ignored; TRAIN_PAT and IDLE_PAT are truncated to WIDTH.

Optional Feature:
- Macro ADCTX_PRBS_EN.
- Defined:
  - Adds input port PRBS (1 bit) and a PRBS-7 LFSR (x^7+x^6+1), seed 7'h7F at reset.
  - At a boundary with TRAIN=0 and PRBS=1, the loaded word is lfsr[WIDTH-1:0]; the LFSR advances one step; the buffer is not popped and no underrun is counted.
  - Priority: TRAIN > PRBS > buffer > idle.
- Undefined: PRBS port and LFSR absent; behaviour exactly as above.

Decomposition:
- Shared package adc_xmit_pkg holds:
  - state enum {RUN, TRAIN};
  - the default TRAIN_PAT / IDLE_PAT constants;
  - the PRBS-7 tap mask and seed, shared with the receive-side pattern checker.
- One natural sub-module: xmit_fifo2, the 2-entry valid/ready buffer with count.

Test Plan:
- Reset release, DVALID=0 for 18 cycles -> SOUT all 0; FRAME at cycles 1,7,13; UNDERRUN pulses 3; UCNT=3.
- Push 6'h2D into empty buffer at cnt=0 -> SOUT 1,0,1,1,0,1 starting the cycle after the next boundary, FRAME on the first bit; UCNT unchanged for that word.
- Push 6'h01, 6'h3E, 6'h15 on consecutive cycles -> DREADY low after the second push until first pop; all three are serialized back-to-back in order with no idle word between them.
- Hold TRAIN=1 while 2 words are buffered -> TRAINING=1 from the next boundary; SOUT repeats 111000; buffer held. Drop TRAIN -> buffered words follow immediately, with no underrun.
- Assert RST for 1 cycle mid-word, after bit 3 of 6'h2A -> remaining bits dropped; post-reset state as on initial reset; buffered words lost.
- With ADCTX_PRBS_EN: PRBS=1 after reset -> first word 6'h3F, next words follow the LFSR sequence; the sequence repeats after 127 words.
